nibble_assembler: RTL
=====================

NIBBLE_ASSEMBLER -- requirements
Module: nibble_assembler

Interface
REQ-001 SHALL expose ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL expose: reset_L  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose: NIBBLE_IN  input  [3:0][31:0]  four lanes from the upstream selector stage; only bits [3:0] of each lane carry data.
REQ-004 SHALL expose: in_valid  input  1  NIBBLE_IN holds a valid lane set.
REQ-005 SHALL expose: in_ready  output  1  block accepts the lane set this cycle.
REQ-006 SHALL expose: flush  input  1  forces out a pending half-word.
REQ-007 SHALL expose: word_out  output  32  FIFO head word.
REQ-008 SHALL expose: out_valid  output  1  word_out is valid.
REQ-009 SHALL expose: out_ready  input  1  consumer takes word_out.
REQ-010 SHALL expose: fifo_count  output  3  occupied FIFO entries, 0..4.

Function
REQ-011 SHALL define the accept event as in_valid & in_ready, and the pop event as out_valid & out_ready.
REQ-012 SHALL pack each accepted lane set into half-word H = {NIBBLE_IN[3][3:0], NIBBLE_IN[2][3:0], NIBBLE_IN[1][3:0], NIBBLE_IN[0][3:0]}.
REQ-013 SHALL use a two-state FSM:
- LOW: on accept, store H in the hold register and go to HIGH.
- HIGH: on accept, push {H, hold} into the FIFO and go to LOW.
REQ-014 SHALL drive in_ready = !flush & (state==LOW | fifo_count<4).
REQ-015 SHALL, on flush in HIGH with fifo_count<4, push {16'h0000, hold} and go to LOW; flush in LOW, or with the FIFO full, SHALL have no effect.
REQ-016 SHALL implement a 4-entry, 32-bit, first-in first-out buffer; out_valid = (fifo_count!=0); word_out = head entry.
REQ-017 SHALL keep fifo_count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-018 SHALL make a pushed word visible on word_out/out_valid on the cycle after the push edge when the FIFO was empty (1-cycle latency).
REQ-019 SHALL use 2-bit read and write pointers that wrap 3->0.
REQ-020 SHALL hold word_out stable while out_valid=1 and out_ready=0.

Reset
REQ-021 SHALL, on reset_L=0 and independent of clk: state=LOW, hold=0, pointers=0, fifo_count=0, out_valid=0, word_out=0, in_ready=1 (subject to flush).
REQ-022 SHALL, on reset asserted mid-operation, discard the pending half-word and all FIFO contents.

Configuration
REQ-023 SHALL, when NIBBLE_ASM_ERR_EN is defined, add output err_out (1 bit, reset 0), set sticky on any accept where any lane has bits [31:4] != 0 and cleared only by reset.
REQ-024 SHALL, without NIBBLE_ASM_ERR_EN, omit err_out and ignore lane bits [31:4].

Structure
REQ-025 SHALL place LANES=4, FIFO_DEPTH=4 and the FSM state enum (LOW, HIGH) in shared package nibble_pkg.
REQ-026 SHALL implement the buffer as sub-module nibble_fifo (32-bit, depth 4, push/pop/count), instantiated once.

Verification
REQ-027 Bench SHALL cover: lanes 0x1,0x2,0x3,0x4 then 0x5,0x6,0x7,0x8 with out_ready=1 -> word_out=0x87654321, out_valid on the cycle after the second accept.
REQ-028 Bench SHALL cover: out_ready=0 and eight accepts -> fifo_count=4; in LOW a ninth accept is taken (in_ready=1); in HIGH in_ready=0 until a pop.
REQ-029 Bench SHALL cover: a single accept of 0xA,0xB,0xC,0xD, then flush -> word_out=0x0000DCBA, state=LOW.
REQ-030 Bench SHALL cover: FIFO at 2 entries, push and pop on the same cycle -> fifo_count stays 2 and order is preserved across pointer wrap.
REQ-031 Bench SHALL cover: reset_L pulsed low between clk edges while in HIGH with 3 entries -> outputs clear immediately and the next accept starts in LOW.
REQ-032 Bench SHALL cover, with NIBBLE_ASM_ERR_EN: lane 2 = 0x00000013 accepted -> err_out=1 and stays 1 until reset.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared constants and FSM state type for the nibble assembler.
package nibble_pkg;

  localparam int LANES      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LANE_W     = 32;
  localparam int NIBBLE_W   = 4;
  localparam int HALF_W     = LANES * NIBBLE_W;
  localparam int WORD_W     = 2 * HALF_W;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } asm_state_e;

endpackage

// File: rtl/nibble_fifo.sv
// Four-entry, 32-bit FIFO with a combinational head and an occupancy count.
module nibble_fifo
  import nibble_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Guard against overflow/underflow even if the parent misbehaves.
  assign do_push = push && (count_q != CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/nibble_assembler.sv
// Packs pairs of 4-lane nibble sets into 32-bit words and queues them in a FIFO.
// Optional sticky lane-overflow flag err_out when NIBBLE_ASM_ERR_EN is defined.
module nibble_assembler
  import nibble_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [LANES-1:0][LANE_W-1:0]  NIBBLE_IN,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [WORD_W-1:0]             word_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              fifo_count
`ifdef NIBBLE_ASM_ERR_EN
  ,
  output logic                          err_out
`endif
);

  asm_state_e        state_q;
  logic [HALF_W-1:0] hold_q;
  logic [HALF_W-1:0] half_word;
  logic [LANES-1:0]  lane_overflow;
  logic              fifo_full, accept, flush_push, push, pop;
  logic [WORD_W-1:0] push_data;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign half_word[gi*NIBBLE_W +: NIBBLE_W] = NIBBLE_IN[gi][NIBBLE_W-1:0];
      assign lane_overflow[gi] = |NIBBLE_IN[gi][LANE_W-1:NIBBLE_W];
    end
  endgenerate

  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  // In LOW an accept only loads the hold register, so a full FIFO need not stall it.
  assign in_ready   = !flush && ((state_q == LOW) || !fifo_full);
  assign accept     = in_valid && in_ready;
  assign flush_push = flush && (state_q == HIGH) && !fifo_full;
  assign push       = (accept && (state_q == HIGH)) || flush_push;
  assign push_data  = flush_push ? {{HALF_W{1'b0}}, hold_q} : {half_word, hold_q};
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= LOW;
      hold_q  <= '0;
    end else begin
      case (state_q)
        LOW: begin
          if (accept) begin
            hold_q  <= half_word;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (accept || flush_push) state_q <= LOW;
        end
        default: state_q <= LOW;
      endcase
    end
  end

`ifdef NIBBLE_ASM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                     err_q <= 1'b0;
    else if (accept && |lane_overflow) err_q <= 1'b1;
  end

  assign err_out = err_q;
`else
  logic unused_lane_overflow;
  assign unused_lane_overflow = |lane_overflow;
`endif

  nibble_fifo u_fifo (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (word_out),
    .count     (fifo_count)
  );

endmodule
